fetch_sequencer: RTL
====================

# fetch_sequencer

Program-counter and instruction-fetch sequencer: the producer side of the instruction bus that feeds the control decoder. On a Start pulse it walks the instruction ROM from a given start address and presents one instruction per cycle. It applies taken branches from the decoder/ALU and honours a stall input. It stops on the halt word or on PC wrap-around, then raises Done until the next Start.

## Interface
- PC_W, 10, program counter / ROM address width
- MCODE_W, 9, instruction word width
- HALT_CODE, all-ones of MCODE_W (9'h1FF), instruction word that ends a run
- Clk  input  1  clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-low reset
- Start  input  1  begin run; sampled only in IDLE or DONE
- StartPC  input  PC_W  first instruction address, captured with an accepted Start
- InstrRom  input  MCODE_W  ROM data at ProgAddr (combinational ROM)
- Branch  input  1  decoder says current instruction is a branch
- BranchTaken  input  1  branch condition true (e.g. BNE operands differ)
- TargetAddr  input  PC_W  branch target for the current instruction
- Stall  input  1  hold current instruction this cycle
- ProgAddr  output  PC_W  current PC, drives ROM address
- Instr  output  MCODE_W  current instruction (equals InstrRom)
- Opcode  output  3  Instr[MCODE_W-1 -: 3], to decoder
- InstrValid  output  1  Instr is live and may be executed
- Done  output  1  run finished
- Fault  output  1  run ended by PC wrap, not halt
- RetireCount  output  16  instructions retired in current/last run

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE: InstrValid=0. Start=1 -> RUN; PC<=StartPC, RetireCount<=0, Fault<=0.
- RUN: InstrValid=1. Each cycle with Stall=0 retires the instruction at PC:
  - InstrRom==HALT_CODE -> DONE, PC held, RetireCount+1 (the halt counts), Done<=1.
  - else Branch&&BranchTaken -> PC<=TargetAddr.
  - else PC==2^PC_W-1 -> DONE, Fault<=1, Done<=1, PC held (no wrap to 0); the instruction still retires.
  - else PC<=PC+1.
  - Halt takes priority over branch; a taken branch at max PC is not a fault.
- Stall=1 in RUN: PC, state, RetireCount held; InstrValid stays 1; Branch/halt ignored that cycle.
- Start in RUN is ignored.
- DONE: Done=1, InstrValid=0, ProgAddr holds last PC, Fault/RetireCount hold. Start=1 -> RUN as from IDLE, Done<=0 and Fault<=0 on the same edge.
- RetireCount saturates at 16'hFFFF; no wrap.
- Branch with BranchTaken=0 is plain PC+1.
- Opcode/Instr are pure pass-through of InstrRom; ProgAddr is the PC register.

## Timing
- Reset (asserted low, async): state=IDLE, PC=0, ProgAddr=0, Done=0, Fault=0, RetireCount=0, InstrValid=0. Instr/Opcode follow InstrRom at address 0. Reset mid-run aborts immediately with no completion.
- Start accepted at edge N: ProgAddr=StartPC and InstrValid=1 from cycle N+1.
- One instruction per unstalled cycle; branch redirect takes effect on the next edge, with zero bubbles.
- Halt retired at edge N: Done=1, InstrValid=0 from N+1.
- Done stays high until the edge that accepts the next Start.
- Start and Stall in the same DONE cycle: Start wins, Stall ignored.

## Test plan
- Reset low mid-RUN at PC=0x023 -> outputs go to reset values immediately; Start with StartPC=0 after release -> ProgAddr 0 next cycle.
- Linear run: StartPC=0x010, ROM 0x010..0x013 non-halt, 0x014=0x1FF -> ProgAddr 0x010..0x014 on consecutive cycles, Done=1 the cycle after 0x014, RetireCount=5, Fault=0.
- Taken branch at 0x005 to TargetAddr=0x040 (Branch=1, BranchTaken=1) -> next ProgAddr=0x040. Same with BranchTaken=0 -> 0x006.
- Stall held 3 cycles at PC=0x008 -> ProgAddr stays 0x008, RetireCount unchanged, then advances to 0x009.
- Wrap: StartPC=0x3FE, no halt, no branch -> retires 0x3FE and 0x3FF, then Done=1, Fault=1, ProgAddr=0x3FF, RetireCount=2.
- Restart from DONE with StartPC=0x100 -> Done and Fault clear on the accepting edge, RetireCount=0, ProgAddr=0x100. Start pulses during RUN have no effect.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Instruction-fetch bus between the fetch sequencer (master) and the
// ROM/decoder side (slave).
interface fetch_sequencer_if #(
  parameter int PC_W    = 10,
  parameter int MCODE_W = 9
);
  logic               start;
  logic [PC_W-1:0]    start_pc;
  logic [MCODE_W-1:0] instr_rom;
  logic               branch;
  logic               branch_taken;
  logic [PC_W-1:0]    target_addr;
  logic               stall;
  logic [PC_W-1:0]    prog_addr;
  logic [MCODE_W-1:0] instr;
  logic [2:0]         opcode;
  logic               instr_valid;
  logic               done;
  logic               fault;
  logic [15:0]        retire_count;

  modport master (
    input  start, start_pc, instr_rom, branch, branch_taken, target_addr, stall,
    output prog_addr, instr, opcode, instr_valid, done, fault, retire_count
  );

  modport slave (
    output start, start_pc, instr_rom, branch, branch_taken, target_addr, stall,
    input  prog_addr, instr, opcode, instr_valid, done, fault, retire_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and instruction-fetch sequencer: walks the instruction ROM
// from a start address, follows taken branches, honours stall, ends on halt or PC wrap.
module fetch_sequencer #(
  parameter int PC_W    = 10,
  parameter int MCODE_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_sequencer_if.master bus
);

  localparam logic [MCODE_W-1:0] HALT_CODE = '1;
  localparam logic [PC_W-1:0]    PC_MAX    = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [PC_W-1:0] pc;
  logic        instr_valid_q;
  logic        done_q;
  logic        fault_q;
  logic [15:0] retire_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pc            <= '0;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
      retire_q      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // Start wins over a simultaneous stall while idle or finished.
          if (bus.start) begin
            state         <= S_RUN;
            pc            <= bus.start_pc;
            instr_valid_q <= 1'b1;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            retire_q      <= '0;
          end
        end
        S_RUN: begin
          if (!bus.stall) begin
            retire_q <= sat_inc16(retire_q);
            if (bus.instr_rom == HALT_CODE) begin
              state         <= S_DONE;
              done_q        <= 1'b1;
              instr_valid_q <= 1'b0;
            end else if (bus.branch && bus.branch_taken) begin
              pc <= bus.target_addr;
            end else if (pc == PC_MAX) begin
              // Running off the top of the ROM ends the run rather than wrapping.
              state         <= S_DONE;
              done_q        <= 1'b1;
              fault_q       <= 1'b1;
              instr_valid_q <= 1'b0;
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        default: begin
          state         <= S_IDLE;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prog_addr    = pc;
  assign bus.instr        = bus.instr_rom;
  assign bus.opcode       = bus.instr_rom[MCODE_W-1 -: 3];
  assign bus.instr_valid  = instr_valid_q;
  assign bus.done         = done_q;
  assign bus.fault        = fault_q;
  assign bus.retire_count = retire_q;

endmodule
